// File: rtl/mul_pkg.sv
// Shared types and constants for the iterative MUL sequencer.
// Holds the FSM encoding, default operand width, counter width and register tag width.
package mul_pkg;

   localparam int MUL_WIDTH = 64;
   localparam int MUL_CNT_W = 7;
   localparam int REG_W     = 5;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

endpackage

// File: rtl/mul_shift_add_dp.sv
// Radix-2 shift-add datapath: multiplicand, multiplier and accumulator with load/step/hold.
// MUL_EARLY_TERM_EN: o_last also asserts once the post-shift multiplier is zero.
module mul_shift_add_dp #(
   parameter int WIDTH = 64
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             i_load,
   input  logic             i_step,
   input  logic             i_cnt_last,
   input  logic [WIDTH-1:0] i_op_a,
   input  logic [WIDTH-1:0] i_op_b,
   output logic [WIDTH-1:0] o_acc_next,
   output logic             o_last
);

   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [WIDTH-1:0] r_acc;
   logic [WIDTH-1:0] w_b_next;

   assign w_b_next   = r_b >> 1;
   assign o_acc_next = r_acc + (r_b[0] ? r_a : '0);

`ifdef MUL_EARLY_TERM_EN
   assign o_last = i_cnt_last | (w_b_next == '0);
`else
   assign o_last = i_cnt_last;
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_a   <= '0;
         r_b   <= '0;
         r_acc <= '0;
      end else if (i_load) begin
         r_a   <= i_op_a;
         r_b   <= i_op_b;
         r_acc <= '0;
      end else if (i_step) begin
         r_a   <= r_a << 1;
         r_b   <= w_b_next;
         r_acc <= o_acc_next;
      end
   end

endmodule

// File: rtl/mul_sequencer.sv
// Multi-cycle MUL controller: FSM, iteration counter, stall/done and the held result/tag.
// Build option MUL_EARLY_TERM_EN (in mul_shift_add_dp) stops once remaining multiplier bits are zero.
module mul_sequencer
   import mul_pkg::*;
#(
   parameter int WIDTH = MUL_WIDTH,
   parameter int CNT_W = MUL_CNT_W
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             start,
   input  logic             flush,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   input  logic [REG_W-1:0] dest_in,
   output logic             busy,
   output logic             stall,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic [REG_W-1:0] dest_out
);

   state_t           r_state;
   state_t           w_state_nxt;
   logic [CNT_W-1:0] r_cnt;
   logic [REG_W-1:0] r_dest;
   logic [WIDTH-1:0] r_result;
   logic [REG_W-1:0] r_dest_out;
   logic [WIDTH-1:0] w_acc_next;
   logic             w_accept;
   logic             w_load;
   logic             w_step;
   logic             w_cnt_last;
   logic             w_last;

   assign w_accept   = start & ~flush & ((r_state == S_IDLE) | (r_state == S_DONE));
   assign w_cnt_last = (r_cnt == CNT_W'(WIDTH - 1));
   assign result     = r_result;
   assign dest_out   = r_dest_out;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_state <= S_IDLE;
      else          r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  w_state_nxt = w_accept ? S_RUN : S_IDLE;
         S_RUN: begin
            if (flush)       w_state_nxt = S_IDLE;
            else if (w_last) w_state_nxt = S_DONE;
         end
         S_DONE:  w_state_nxt = w_accept ? S_RUN : S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // stall is raised combinationally on the start cycle so decode freezes before the accept edge
   always_comb begin
      busy   = (r_state == S_RUN);
      done   = (r_state == S_DONE);
      stall  = (start & ((r_state == S_IDLE) | (r_state == S_DONE))) | (r_state == S_RUN);
      w_load = w_accept;
      w_step = (r_state == S_RUN) & ~flush;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_cnt  <= '0;
         r_dest <= '0;
      end else if (w_load) begin
         r_cnt  <= '0;
         r_dest <= dest_in;
      end else if (w_step) begin
         r_cnt  <= r_cnt + 1'b1;
      end
   end

   // result/tag only change on a completed RUN->DONE transition, never on flush or idle
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_result   <= '0;
         r_dest_out <= '0;
      end else if (w_step & w_last) begin
         r_result   <= w_acc_next;
         r_dest_out <= r_dest;
      end
   end

   mul_shift_add_dp #(.WIDTH(WIDTH)) u_dp (
      .clk        (clk),
      .reset_n    (reset_n),
      .i_load     (w_load),
      .i_step     (w_step),
      .i_cnt_last (w_cnt_last),
      .i_op_a     (op_a),
      .i_op_b     (op_b),
      .o_acc_next (w_acc_next),
      .o_last     (w_last)
   );

endmodule

// File: tb/tb_mul_sequencer.sv
// Directed bench for mul_sequencer: table of products plus reset, flush and back-to-back sequences.
module tb_mul_sequencer;

   logic        clk;
   logic        reset_n;
   logic        start;
   logic        flush;
   logic [63:0] op_a;
   logic [63:0] op_b;
   logic [4:0]  dest_in;
   logic        busy;
   logic        stall;
   logic        done;
   logic [63:0] result;
   logic [4:0]  dest_out;

   int total;
   int bad;

   typedef struct {
      logic [63:0] a;
      logic [63:0] b;
      logic [4:0]  dest;
      logic [63:0] prod;
      string       name;
   } vec_t;

   vec_t vecs[7];

   mul_sequencer dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .start    (start),
      .flush    (flush),
      .op_a     (op_a),
      .op_b     (op_b),
      .dest_in  (dest_in),
      .busy     (busy),
      .stall    (stall),
      .done     (done),
      .result   (result),
      .dest_out (dest_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic int exp_lat(input logic [63:0] b);
`ifdef MUL_EARLY_TERM_EN
      int n;
      n = 1;
      for (int i = 0; i < 64; i++) if (b[i]) n = i + 1;
      return n;
`else
      return 64;
`endif
   endfunction

   // counts edges after the accept edge until done is seen; bounded
   task automatic wait_done(input string name, output int lat);
      lat = 0;
      for (int i = 0; i < 200; i++) begin
         tick();
         lat++;
         if (done) break;
      end
      check({name, "_done_seen"}, {63'd0, done}, 64'd1);
   endtask

   task automatic run_mul(input logic [63:0] a, input logic [63:0] b, input logic [4:0] d,
                          input logic [63:0] prod, input string name);
      int lat;
      start = 1'b1; op_a = a; op_b = b; dest_in = d;
      #1;
      check({name, "_stall_start"}, {63'd0, stall}, 64'd1);
      tick();
      start = 1'b0; op_a = '0; op_b = '0; dest_in = '0;
      check({name, "_busy"}, {63'd0, busy}, 64'd1);
      wait_done(name, lat);
      check({name, "_latency"}, 64'(lat), 64'(exp_lat(b)));
      check({name, "_result"}, result, prod);
      check({name, "_dest"}, {59'd0, dest_out}, {59'd0, d});
      check({name, "_stall_done"}, {63'd0, stall}, 64'd0);
      tick();
      check({name, "_done_pulse"}, {63'd0, done}, 64'd0);
   endtask

   initial begin
      int lat;
      total = 0; bad = 0;
      vecs[0] = '{64'd7, 64'd6, 5'd9, 64'd42, "basic"};
      vecs[1] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 5'd1, 64'hFFFF_FFFF_FFFF_FFFE, "wrap_max"};
      vecs[2] = '{64'hFFFF_FFFF_FFFF_FFFD, 64'd4, 5'd2, 64'hFFFF_FFFF_FFFF_FFF4, "neg3x4"};
      vecs[3] = '{64'd123, 64'd0, 5'd3, 64'd0, "zero_b"};
      vecs[4] = '{64'h1_0000_0000, 64'h1_0000_0000, 5'd4, 64'd0, "wrap_2pow64"};
      vecs[5] = '{64'd3, 64'h8000_0000_0000_0001, 5'd31, 64'h8000_0000_0000_0003, "top_bit"};
      vecs[6] = '{64'd12345, 64'd1000, 5'd17, 64'd12345000, "decimal"};

      reset_n = 1'b0; start = 1'b0; flush = 1'b0;
      op_a = '0; op_b = '0; dest_in = '0;
      #12;
      check("rst_busy", {63'd0, busy}, 64'd0);
      check("rst_stall", {63'd0, stall}, 64'd0);
      check("rst_done", {63'd0, done}, 64'd0);
      check("rst_result", result, 64'd0);
      check("rst_dest", {59'd0, dest_out}, 64'd0);
      reset_n = 1'b1;
      tick();

      // reset asserted mid-RUN
      start = 1'b1; op_a = 64'd3; op_b = 64'd5; dest_in = 5'd7;
      tick();
      start = 1'b0;
      repeat (5) tick();
      check("midrun_busy_before", {63'd0, busy}, 64'd1);
      #2 reset_n = 1'b0;
      #1;
      check("midrun_rst_busy", {63'd0, busy}, 64'd0);
      check("midrun_rst_stall", {63'd0, stall}, 64'd0);
      check("midrun_rst_done", {63'd0, done}, 64'd0);
      check("midrun_rst_result", result, 64'd0);
      #3 reset_n = 1'b1;
      tick();
      check("post_rst_busy", {63'd0, busy}, 64'd0);
      check("post_rst_stall", {63'd0, stall}, 64'd0);

      for (int i = 0; i < 7; i++)
         run_mul(vecs[i].a, vecs[i].b, vecs[i].dest, vecs[i].prod, vecs[i].name);

      // flush 10 edges after accept; previous result 42 must survive
      run_mul(64'd7, 64'd6, 5'd9, 64'd42, "pre_flush");
      start = 1'b1; op_a = 64'd11; op_b = 64'hFFFF; dest_in = 5'd12;
      tick();
      start = 1'b0;
      repeat (9) tick();
      flush = 1'b1;
      tick();
      flush = 1'b0;
      check("flush_busy", {63'd0, busy}, 64'd0);
      check("flush_done", {63'd0, done}, 64'd0);
      check("flush_result", result, 64'd42);
      begin
         int seen;
         seen = 0;
         for (int i = 0; i < 70; i++) begin
            tick();
            if (done) seen++;
         end
         check("flush_no_done", 64'(seen), 64'd0);
      end
      check("flush_dest", {59'd0, dest_out}, 64'd9);
      run_mul(64'd2, 64'd3, 5'd10, 64'd6, "after_flush");

      // start with flush in IDLE is not accepted
      start = 1'b1; flush = 1'b1; op_a = 64'd4; op_b = 64'd4;
      #1;
      check("idle_flush_stall", {63'd0, stall}, 64'd1);
      tick();
      start = 1'b0; flush = 1'b0;
      check("idle_flush_busy", {63'd0, busy}, 64'd0);
      check("idle_flush_result", result, 64'd6);

      // back-to-back: new request accepted in the DONE cycle
      start = 1'b1; op_a = 64'd3; op_b = 64'd7; dest_in = 5'd5;
      tick();
      start = 1'b0;
      wait_done("b2b_first", lat);
      check("b2b_first_lat", 64'(lat), 64'(exp_lat(64'd7)));
      check("b2b_first_result", result, 64'd21);
      start = 1'b1; op_a = 64'd5; op_b = 64'd5; dest_in = 5'd6;
      #1;
      check("b2b_stall_done", {63'd0, stall}, 64'd1);
      tick();
      start = 1'b0;
      check("b2b_rerun_busy", {63'd0, busy}, 64'd1);
      check("b2b_rerun_done", {63'd0, done}, 64'd0);
      check("b2b_hold_result", result, 64'd21);
      wait_done("b2b_second", lat);
      check("b2b_second_lat", 64'(lat), 64'(exp_lat(64'd5)));
      check("b2b_second_result", result, 64'd25);
      check("b2b_second_dest", {59'd0, dest_out}, 64'd6);
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
